// File: rtl/countdown_timer.sv
// Loadable down-counter with a valid/ready start request and a held expiry
// event. The expiry event waits for its handshake and cannot be aborted.
module countdown_timer #(
    parameter int CounterWidth = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_valid_i,
    output logic                    start_ready_o,
    input  logic [CounterWidth-1:0] start_value_i,
    input  logic                    en_i,
    input  logic                    abort_i,
    output logic [CounterWidth-1:0] count_o,
    output logic                    busy_o,
    output logic                    expire_valid_o,
    input  logic                    expire_ready_i
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_EXPIRE = 2'd2
    } state_e;

    localparam logic [CounterWidth-1:0] CountZero = {CounterWidth{1'b0}};
    localparam logic [CounterWidth-1:0] CountOne  = CounterWidth'(1'b1);

    state_e                  state_r;
    state_e                  state_next_s;
    logic [CounterWidth-1:0] count_r;
    logic [CounterWidth-1:0] count_next_s;

    // State and count registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
            count_r <= CountZero;
        end else begin
            state_r <= state_next_s;
            count_r <= count_next_s;
        end
    end

    // Next-state and next-count decode
    always_comb begin
        state_next_s = state_r;
        count_next_s = count_r;
        case (state_r)
            ST_IDLE: begin
                if (start_valid_i) begin
                    if (start_value_i == CountZero) begin
                        state_next_s = ST_EXPIRE;
                        count_next_s = CountZero;
                    end else begin
                        state_next_s = ST_RUN;
                        count_next_s = start_value_i;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort_i) begin
                    state_next_s = ST_IDLE;
                    count_next_s = CountZero;
                end else if (en_i) begin
                    // A zero count here is unreachable; treat it as expiry rather than wrap.
                    if (count_r <= CountOne) begin
                        state_next_s = ST_EXPIRE;
                        count_next_s = CountZero;
                    end else begin
                        count_next_s = count_r - CountOne;
                    end
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_EXPIRE: begin
                if (expire_ready_i) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_EXPIRE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                count_next_s = CountZero;
            end
        endcase
    end

    assign count_o        = count_r;
    assign start_ready_o  = (state_r == ST_IDLE);
    assign busy_o         = (state_r == ST_RUN);
    assign expire_valid_o = (state_r == ST_EXPIRE);

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: a cycle model pushes expected outputs
// per driven cycle, popped and compared one time step after each rising edge.
`timescale 1ns/1ps
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_valid = 1'b0;
    logic [7:0] start_value = 8'd0;
    logic       en = 1'b0;
    logic       abort = 1'b0;
    logic       expire_ready = 1'b0;
    logic       start_ready;
    logic [7:0] count;
    logic       busy;
    logic       expire_valid;

    logic       sv4 = 1'b0;
    logic [3:0] val4 = 4'd0;
    logic       en4 = 1'b0;
    logic       ab4 = 1'b0;
    logic       rdy4 = 1'b0;
    logic       sr4;
    logic [3:0] count4;
    logic       busy4;
    logic       ev4;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic [7:0] count;
        logic       busy;
        logic       ev;
        logic       sr;
    } exp_t;
    exp_t sb_q[$];

    int m_state = 0;  // 0 idle, 1 run, 2 expire
    int m_count = 0;
    int lat;

    always #5 clk = ~clk;

    countdown_timer #(.CounterWidth(8)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .start_valid_i(start_valid), .start_ready_o(start_ready),
        .start_value_i(start_value), .en_i(en), .abort_i(abort),
        .count_o(count), .busy_o(busy),
        .expire_valid_o(expire_valid), .expire_ready_i(expire_ready)
    );

    countdown_timer #(.CounterWidth(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n),
        .start_valid_i(sv4), .start_ready_o(sr4),
        .start_value_i(val4), .en_i(en4), .abort_i(ab4),
        .count_o(count4), .busy_o(busy4),
        .expire_valid_o(ev4), .expire_ready_i(rdy4)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of the 8-bit timer: drive, model, push, clock, pop and compare.
    task automatic cycle(input logic sv, input logic [7:0] v, input logic e,
                         input logic a, input logic r, input string tag);
        exp_t x;
        start_valid  = sv;
        start_value  = v;
        en           = e;
        abort        = a;
        expire_ready = r;
        if (m_state == 0) begin
            if (sv) begin
                m_count = int'(v);
                m_state = (v == 8'd0) ? 2 : 1;
            end
        end else if (m_state == 1) begin
            if (a) begin
                m_state = 0;
                m_count = 0;
            end else if (e) begin
                m_count = m_count - 1;
                if (m_count == 0) m_state = 2;
            end
        end else begin
            if (r) m_state = 0;
        end
        x.count = 8'(m_count);
        x.busy  = (m_state == 1);
        x.ev    = (m_state == 2);
        x.sr    = (m_state == 0);
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        x = sb_q.pop_front();
        check_eq({tag, ".count"}, 32'(count), 32'(x.count));
        check_eq({tag, ".busy"}, 32'(busy), 32'(x.busy));
        check_eq({tag, ".ev"}, 32'(expire_valid), 32'(x.ev));
        check_eq({tag, ".ready"}, 32'(start_ready), 32'(x.sr));
        start_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, ".count"}, 32'(count), 32'd0);
        check_eq({tag, ".busy"}, 32'(busy), 32'd0);
        check_eq({tag, ".ev"}, 32'(expire_valid), 32'd0);
        check_eq({tag, ".ready"}, 32'(start_ready), 32'd1);
        m_state = 0;
        m_count = 0;
    endtask

    initial begin
        #12;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // N=5 continuous enable
        cycle(1'b1, 8'd5, 1'b1, 1'b0, 1'b1, "n5_accept");
        lat = 0;
        while (!expire_valid && lat < 20) begin
            cycle(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, "n5_run");
            lat++;
        end
        check_eq("n5_latency", 32'(lat), 32'd5);
        cycle(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, "n5_done");

        // N=4 with a three-cycle pause
        cycle(1'b1, 8'd4, 1'b1, 1'b0, 1'b1, "n4_accept");
        lat = 0;
        while (!expire_valid && lat < 20) begin
            cycle(1'b0, 8'd0, (lat == 0 || lat >= 4), 1'b0, 1'b1, "n4_run");
            lat++;
        end
        check_eq("n4_latency", 32'(lat), 32'd7);
        cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, "n4_done");

        // N=0, expiry held with ready low while abort/en toggle
        cycle(1'b1, 8'd0, 1'b0, 1'b0, 1'b0, "n0_accept");
        check_eq("n0_latency_ev", 32'(expire_valid), 32'd1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'd7, i[0], 1'b1, 1'b0, "n0_hold");
        cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, "n0_release");
        cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, "n0_idle");

        // N=10, ignored start during run, abort at count 6
        cycle(1'b1, 8'd10, 1'b1, 1'b0, 1'b1, "ab_accept");
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'd3, 1'b1, 1'b0, 1'b1, "ab_run");
        check_eq("ab_count6", 32'(count), 32'd6);
        cycle(1'b0, 8'd0, 1'b0, 1'b1, 1'b1, "ab_abort");
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, "ab_idle");

        // Asynchronous reset mid-RUN at count 3
        cycle(1'b1, 8'd5, 1'b1, 1'b0, 1'b1, "rr_accept");
        cycle(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, "rr_run");
        cycle(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, "rr_run");
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_run");
        #1 rst_n = 1'b1;

        // Asynchronous reset mid-EXPIRE, then immediate accept after release
        cycle(1'b1, 8'd0, 1'b0, 1'b0, 1'b0, "re_accept");
        cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, "re_hold");
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_exp");
        #1 rst_n = 1'b1;
        cycle(1'b1, 8'd2, 1'b1, 1'b0, 1'b1, "post_rst_accept");
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, "post_rst_run");

        // Max load on the 4-bit instance: no wrap
        sv4 = 1'b1; val4 = 4'd15; en4 = 1'b1; rdy4 = 1'b0;
        @(posedge clk); #1;
        sv4 = 1'b0;
        check_eq("w4_load", 32'(count4), 32'd15);
        for (int i = 1; i <= 15; i++) begin
            @(posedge clk); #1;
            check_eq("w4_count", 32'(count4), 32'(15 - i));
        end
        check_eq("w4_ev", 32'(ev4), 32'd1);
        @(posedge clk); #1;
        check_eq("w4_nowrap", 32'(count4), 32'd0);
        check_eq("w4_hold_ev", 32'(ev4), 32'd1);
        rdy4 = 1'b1;
        @(posedge clk); #1;
        check_eq("w4_idle", 32'(sr4), 32'd1);
        check_eq("w4_busy", 32'(busy4), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
